instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly upstream of `controller`. It owns the program counter, reads 16-bit instruction words from a synchronous-read instruction RAM, and drives the registered `IR` bus that the controller decodes into its `OPs` control word. The controller requests each fetch and requests PC redirection. Redirection is either an unconditional jump or a jump-if-zero evaluated against the datapath `z` flag.

## Interface
Parameters:
- `ADDR_W`, 8: PC and instruction-RAM address width.
- `IR_W`, 16: instruction word width; must match controller `IR`.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rstn`, in, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `fetch_req`, in, 1: controller requests the next instruction.
- `jump`, in, 1: unconditional redirect, `pc <= br_addr`.
- `jz`, in, 1: redirect only if `z`=1.
- `z`, in, 1: datapath zero flag.
- `br_addr`, in, `ADDR_W`: redirect target.
- `imem_en`, out, 1: instruction-RAM read enable.
- `imem_addr`, out, `ADDR_W`: instruction-RAM read address.
- `imem_rdata`, in, `IR_W`: RAM read data, valid the cycle after `imem_en`.
- `IR`, out, `IR_W`: registered instruction to the controller.
- `ir_valid`, out, 1: one-cycle pulse when `IR` has just been updated.
- `busy`, out, 1: fetch in flight; requests are ignored while high.
- `pc`, out, `ADDR_W`: current program counter.

## Operation
- FSM states:
  - IDLE: accepts commands.
  - ISSUE: `imem_en`=1 and `imem_addr`=`pc`.
  - CAPTURE: RAM data is returning; the block latches it.
- Transitions:
  - IDLE → ISSUE on `fetch_req`.
  - ISSUE → CAPTURE unconditionally.
  - CAPTURE → IDLE unconditionally.
  - Otherwise IDLE holds.
- Redirect, sampled in IDLE only:
  - `jump`=1, or `jz`=1 with `z`=1: `pc <= br_addr` at that edge.
  - `jz`=1 with `z`=0: `pc` unchanged, no other effect.
- Redirect and `fetch_req` in the same IDLE cycle: both take effect. The fetch uses the redirected address, because ISSUE drives `imem_addr` from the already-updated `pc`.
- `jump` and `jz` together: `jump` wins, since both load `br_addr`.
- On the CAPTURE→IDLE edge:
  - `IR <= imem_rdata`.
  - `pc <= pc + 1`, modulo 2^`ADDR_W`; the maximum PC wraps to 0.
  - `ir_valid` is set for exactly one cycle.
- `IR` holds its value between fetches.
- `fetch_req`, `jump` and `jz` asserted in ISSUE or CAPTURE are ignored: not queued, with no effect on `pc`. The controller must re-assert them after `busy` falls.
- `busy` = 1 in ISSUE and CAPTURE, 0 in IDLE. It is combinational from the state register.
- `imem_addr` = `pc` in all states. `imem_en` is high only in ISSUE.

## Timing
- Reset: when `rstn`=0 at an edge, the block goes to IDLE with `pc`=0, `IR`=0, `ir_valid`=0, `imem_en`=0 and `busy`=0. This applies in any state; a fetch in flight is abandoned and `IR` is not updated.
- Fetch latency, with `fetch_req` sampled at edge E0:
  - Cycle after E0: ISSUE (`imem_en`=1).
  - Cycle after E1: CAPTURE (`imem_rdata` valid).
  - After edge E2: the new `IR`, incremented `pc` and `ir_valid`=1 are visible.
- Throughput: one instruction per 3 cycles. `fetch_req` held continuously yields `ir_valid` every 3rd cycle.
- `ir_valid` has no wait-state interaction; the controller must sample `IR` on or after the pulse.
- `rstn` takes priority over every other input at every edge.

## Test plan
- Reset, then preload RAM[0]=0x0015 and RAM[1]=0x00A3, pulse `fetch_req` once:
  - `IR`=0x0015 and `ir_valid`=1 exactly 3 edges after the request.
  - `pc`=1 and `busy`=0 afterwards.
  - A second request gives `IR`=0x00A3 and `pc`=2.
- Hold `fetch_req` high for 9 cycles:
  - Exactly 3 `ir_valid` pulses, 3 cycles apart.
  - `imem_en` high only in ISSUE cycles.
- Redirect checks, each redirect combined with `fetch_req` in the same cycle:
  - `jz`=1, `z`=0: fetches address 0 (`pc` unchanged).
  - `jz`=1, `z`=1, `br_addr`=0x40, RAM[0x40]=0x1234: fetch gives `IR`=0x1234 and `pc`=0x41.
  - `jump`=1, `br_addr`=0x10: `pc`=0x11 after the fetch.
- Commands while busy: jump to 0xFF and fetch (`pc`=0 after), then pulse `jump` with `br_addr`=0x05 during CAPTURE:
  - The jump is ignored.
  - `pc`=0 after that fetch, confirming both the ignore and the wrap.
- Reset mid-fetch with `IR`=0x0015: assert `rstn`=0 in CAPTURE:
  - After the edge: `pc`=0, `IR`=0, `ir_valid`=0, state IDLE.
  - No pulse afterwards.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. It owns the PC, issues synchronous
//               RAM reads and presents the registered IR word to the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int IR_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fetch_req,
    input  logic              jump,
    input  logic              jz,
    input  logic              z,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [IR_W-1:0]   imem_rdata,
    output logic [IR_W-1:0]   IR,
    output logic              ir_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_issue   = 2'd1;
    localparam logic [1:0] c_capture = 2'd2;

    localparam logic [ADDR_W-1:0] c_pc_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [IR_W-1:0]   r_ir;
    logic              r_ir_valid;
    logic              w_redirect;

    assign w_redirect = jump | (jz & z);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= c_idle;
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else begin
            r_ir_valid <= 1'b0;
            case (r_state)
                c_idle: begin
                    // Redirect and fetch may coincide; ISSUE then reads the new PC.
                    if (w_redirect) begin
                        r_pc <= br_addr;
                    end
                    if (fetch_req) begin
                        r_state <= c_issue;
                    end
                end
                c_issue: begin
                    r_state <= c_capture;
                end
                c_capture: begin
                    r_ir       <= imem_rdata;
                    r_pc       <= r_pc + c_pc_one;
                    r_ir_valid <= 1'b1;
                    r_state    <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign imem_en   = (r_state == c_issue);
    assign imem_addr = r_pc;
    assign busy      = (r_state != c_idle);
    assign IR        = r_ir;
    assign ir_valid  = r_ir_valid;
    assign pc        = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch with a synchronous-read RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rstn;
    logic        fetch_req;
    logic        jump;
    logic        jz;
    logic        z;
    logic [7:0]  br_addr;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] IR;
    logic        ir_valid;
    logic        busy;
    logic [7:0]  pc;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    logic [15:0] mem [256];
    logic [23:0] exp_q [$];

    instr_fetch #(.ADDR_W(8), .IR_W(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fetch_req  (fetch_req),
        .jump       (jump),
        .jz         (jz),
        .z          (z),
        .br_addr    (br_addr),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .IR         (IR),
        .ir_valid   (ir_valid),
        .busy       (busy),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every IR update is matched against the oldest expected {IR, pc}.
    always @(negedge clk) begin
        if (ir_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got IR=0x%0h pc=0x%0h expected no pulse", IR, pc);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("sb_ir", {16'h0, IR}, {16'h0, e[23:8]});
                chk("sb_pc", {24'h0, pc}, {24'h0, e[7:0]});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic do_fetch(input logic j, input logic jzv, input logic zv, input logic [7:0] br,
                            input logic [7:0] exp_addr, input bit jump_in_cap, input bit rst_in_cap);
        @(negedge clk);
        fetch_req = 1'b1; jump = j; jz = jzv; z = zv; br_addr = br;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0; jump = 1'b0; jz = 1'b0; z = 1'b0;
        chk("issue_busy", {31'h0, busy}, 32'd1);
        chk("issue_en", {31'h0, imem_en}, 32'd1);
        chk("issue_addr", {24'h0, imem_addr}, {24'h0, exp_addr});
        chk("issue_novalid", {31'h0, ir_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("cap_busy", {31'h0, busy}, 32'd1);
        chk("cap_en", {31'h0, imem_en}, 32'd0);
        if (jump_in_cap) begin
            jump = 1'b1; br_addr = 8'h05;
        end
        if (rst_in_cap) rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        jump = 1'b0;
        if (rst_in_cap) begin
            chk("rst_pc", {24'h0, pc}, 32'd0);
            chk("rst_ir", {16'h0, IR}, 32'd0);
            chk("rst_valid", {31'h0, ir_valid}, 32'd0);
            chk("rst_busy", {31'h0, busy}, 32'd0);
            rstn = 1'b1;
        end else begin
            chk("done_valid", {31'h0, ir_valid}, 32'd1);
            chk("done_busy", {31'h0, busy}, 32'd0);
            @(negedge clk);
            chk("pulse_width", {31'h0, ir_valid}, 32'd0);
        end
    endtask

    initial begin
        int seen;
        rstn = 1'b0; fetch_req = 1'b0; jump = 1'b0; jz = 1'b0; z = 1'b0; br_addr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        mem[8'h00] = 16'h0015; mem[8'h01] = 16'h00A3;
        mem[8'h02] = 16'h0222; mem[8'h03] = 16'h0333; mem[8'h04] = 16'h0444;
        mem[8'h40] = 16'h1234; mem[8'h10] = 16'h0BEE; mem[8'hFF] = 16'h00FF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pc", {24'h0, pc}, 32'd0);
        chk("reset_ir", {16'h0, IR}, 32'd0);
        chk("reset_valid", {31'h0, ir_valid}, 32'd0);
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_en", {31'h0, imem_en}, 32'd0);
        rstn = 1'b1;

        // Two plain sequential fetches.
        exp_q.push_back({16'h0015, 8'h01});
        do_fetch(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_q.push_back({16'h00A3, 8'h02});
        do_fetch(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);

        // fetch_req held for 9 cycles: pulses on cycles 3, 6, 9.
        exp_q.push_back({16'h0222, 8'h03});
        exp_q.push_back({16'h0333, 8'h04});
        exp_q.push_back({16'h0444, 8'h05});
        seen = 0;
        @(negedge clk);
        fetch_req = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ir_valid === 1'b1) seen++;
            chk("hold_valid", {31'h0, ir_valid}, {31'h0, ((i % 3) == 0)});
            chk("hold_en", {31'h0, imem_en}, {31'h0, ((i % 3) == 1)});
        end
        fetch_req = 1'b0;
        chk("hold_pulses", seen, 32'd3);

        // Redirects combined with a fetch.
        do_reset();
        exp_q.push_back({16'h0015, 8'h01});
        do_fetch(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0);
        exp_q.push_back({16'h1234, 8'h41});
        do_fetch(1'b0, 1'b1, 1'b1, 8'h40, 8'h40, 1'b0, 1'b0);
        exp_q.push_back({16'h0BEE, 8'h11});
        do_fetch(1'b1, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0);

        // Jump to the top address; a jump during CAPTURE must be dropped and the PC wraps.
        exp_q.push_back({16'h00FF, 8'h00});
        do_fetch(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        chk("ignored_jump_pc", {24'h0, pc}, 32'd0);

        // Reset in CAPTURE abandons the fetch.
        exp_q.push_back({16'h0015, 8'h01});
        do_fetch(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_ir", {16'h0, IR}, 32'h0015);
        seen = pulses;
        do_fetch(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("post_rst_no_pulse", pulses - seen, 32'd0);
        chk("post_rst_pc", {24'h0, pc}, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
